ttd_sample_avg: RTL

//   Downstream consumer of the time-to-digital converter (TTD) in the capacitor/comparator

---
 rtl/ttd_sample_avg.sv | 75 +++++++
 1 files changed

// File: rtl/ttd_sample_avg.sv
// ttd_sample_avg: synchronises TTD comparator/period marker, averages 2**LOG2_N codes per output
module ttd_sample_avg #(
  parameter int DW = 8,
  parameter int LOG2_N = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cmp_in,
  input  logic          rst_cap,
  input  logic [DW-1:0] data_in,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [7:0]    miss_cnt,
  output logic          overrun,
  input  logic          clr_stat
);
  localparam int AW = DW + LOG2_N;
  localparam int CW = LOG2_N > 0 ? LOG2_N : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);
  typedef enum logic [1:0] {ALIGN, HOLD, WINDOW, DONE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] cmp_sync, rc_sync;
  logic cmp_s, cmp_s_d, rc, cmp_edge;
  logic [AW-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic accept, miss, complete, load;
  assign cmp_s    = cmp_sync[SYNC_STAGES-1];
  assign rc       = rc_sync[SYNC_STAGES-1];
  assign cmp_edge = cmp_s & ~cmp_s_d;
  assign accept   = en && state == WINDOW && cmp_edge;
  assign miss     = en && state == WINDOW && !cmp_edge && rc;
  assign sum      = acc + AW'(data_in);
  assign complete = accept && cnt == LAST;
  assign load     = complete && (!out_valid || out_ready);
  always_comb begin
    state_nx = state;
    if (!en)
      state_nx = ALIGN;
    else
      case (state)
        ALIGN:   state_nx = rc ? HOLD : ALIGN;
        HOLD:    state_nx = rc ? HOLD : WINDOW;
        WINDOW:  state_nx = rc ? HOLD : cmp_edge ? DONE : WINDOW;
        default: state_nx = rc ? HOLD : DONE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_sync  <= '0;
      rc_sync   <= '0;
      cmp_s_d   <= 1'b0;
      state     <= ALIGN;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      miss_cnt  <= '0;
      overrun   <= 1'b0;
    end else begin
      cmp_sync  <= {cmp_sync[SYNC_STAGES-2:0], cmp_in};
      rc_sync   <= {rc_sync[SYNC_STAGES-2:0], rst_cap};
      cmp_s_d   <= cmp_s;
      state     <= state_nx;
      acc       <= (!en || state == ALIGN || complete) ? '0 : accept ? sum : acc;
      cnt       <= (!en || state == ALIGN || complete) ? '0 : accept ? cnt + 1'b1 : cnt;
      out_valid <= load | (out_valid & ~out_ready);
      out_data  <= load ? sum[AW-1:LOG2_N] : out_data;
      miss_cnt  <= clr_stat ? '0 : (miss && miss_cnt != 8'hff) ? miss_cnt + 8'd1 : miss_cnt;
      overrun   <= clr_stat ? 1'b0 : (complete && !load) ? 1'b1 : overrun;
    end
  end
endmodule
